// File: rtl/router_pkg.sv
// Shared constants and helpers for the router register stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package router_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 2;
    localparam int DEF_CNT_W  = 4;

    // Parity coverage selection
    localparam int PAR_ALL     = 0;  // header + payload
    localparam int PAR_PAYLOAD = 1;  // payload only

    // Width of the header length field that sits above the address bits
    function automatic int len_w(input int data_w, input int addr_w);
        return data_w - addr_w;
    endfunction

endpackage

// File: rtl/router_reg_param_if.sv
// FSM/source/FIFO-side bundle for the router register stage.
// Latency: n/a (wires only).
// Backpressure: fifo_full from the destination, echoed by the FSM state inputs.
interface router_reg_param_if
    import router_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) ();

    logic              pkt_valid;
    logic              fifo_full;
    logic              detect_add;
    logic              lfd_state;
    logic              ld_state;
    logic              laf_state;
    logic              full_state;
    logic              rst_int_reg;
    logic [DATA_W-1:0] data_in;

    logic [DATA_W-1:0] dout;
    logic              err;
    logic              len_err;
    logic              parity_done;
    logic              low_packet_valid;
    logic [CNT_W-1:0]  err_count;

    // Source/FSM side
    modport master (
        output pkt_valid, fifo_full, detect_add, lfd_state, ld_state,
               laf_state, full_state, rst_int_reg, data_in,
        input  dout, err, len_err, parity_done, low_packet_valid, err_count
    );

    // Register stage side
    modport slave (
        input  pkt_valid, fifo_full, detect_add, lfd_state, ld_state,
               laf_state, full_state, rst_int_reg, data_in,
        output dout, err, len_err, parity_done, low_packet_valid, err_count
    );

endinterface

// File: rtl/router_parity_acc.sv
// Running XOR parity and saturating payload byte counter for one packet.
// Latency: 1 cycle from enable to updated parity/count.
// Backpressure: none; caller gates i_pay_en when the byte must not count.
module router_parity_acc #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_clr,
    input  logic              i_hdr_en,
    input  logic [DATA_W-1:0] i_hdr,
    input  logic              i_pay_en,
    input  logic [DATA_W-1:0] i_pay,
    output logic [DATA_W-1:0] o_parity,
    output logic [LEN_W-1:0]  o_pay_cnt
);

    logic [DATA_W-1:0] r_parity;
    logic [LEN_W-1:0]  r_pay_cnt;
    logic [DATA_W-1:0] w_hdr_term;
    logic [DATA_W-1:0] w_pay_term;

    assign w_hdr_term = i_hdr_en ? i_hdr : '0;
    assign w_pay_term = i_pay_en ? i_pay : '0;

    // Accumulate parity and count payload; a new header restarts both
    always_ff @(posedge clock) begin
        if (reset || i_clr) begin
            r_parity  <= '0;
            r_pay_cnt <= '0;
        end else begin
            r_parity <= r_parity ^ w_hdr_term ^ w_pay_term;
            if (i_pay_en && (r_pay_cnt != '1))
                r_pay_cnt <= r_pay_cnt + 1'b1;
        end
    end

    assign o_parity  = r_parity;
    assign o_pay_cnt = r_pay_cnt;

endmodule

// File: rtl/router_reg_param.sv
// Packet register stage: header latch, payload stream, parity and length checks.
// Latency: dout 1 cycle after the qualifying FSM state; checks 1 cycle after parity_done rises.
// Backpressure: a byte arriving while fifo_full is parked in full_byte and replayed in laf_state.
module router_reg_param
    import router_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int PARITY_MODE = PAR_ALL,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic              clock,
    input  logic              reset,
    router_reg_param_if.slave bus
);

    localparam int LEN_W = len_w(DATA_W, ADDR_W);

    logic [DATA_W-1:0] r_dout;
    logic [DATA_W-1:0] r_hold_hdr;
    logic [DATA_W-1:0] r_full_byte;
    logic [DATA_W-1:0] r_pkt_parity;
    logic              r_err;
    logic              r_len_err;
    logic              r_parity_done;
    logic              r_parity_done_d;
    logic              r_low_pkt_vld;
    logic [CNT_W-1:0]  r_err_count;

    logic              w_hdr_cap;
    logic              w_hdr_en;
    logic              w_pay_en;
    logic              w_check;
    logic              w_err_nxt;
    logic              w_len_err_nxt;
    logic [DATA_W-1:0] w_int_parity;
    logic [LEN_W-1:0]  w_pay_cnt;

    assign w_hdr_cap     = bus.detect_add && bus.pkt_valid;
    assign w_hdr_en      = bus.lfd_state && (PARITY_MODE == PAR_ALL);
    assign w_pay_en      = bus.ld_state && bus.pkt_valid && !bus.full_state;
    assign w_check       = r_parity_done && !r_parity_done_d;
    assign w_err_nxt     = (w_int_parity != r_pkt_parity);
    assign w_len_err_nxt = (w_pay_cnt != r_hold_hdr[DATA_W-1:ADDR_W]);

    router_parity_acc #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) u_parity_acc (
        .clock     (clock),
        .reset     (reset),
        .i_clr     (w_hdr_cap),
        .i_hdr_en  (w_hdr_en),
        .i_hdr     (r_hold_hdr),
        .i_pay_en  (w_pay_en),
        .i_pay     (bus.data_in),
        .o_parity  (w_int_parity),
        .o_pay_cnt (w_pay_cnt)
    );

    // FIFO byte: header on lfd, live byte when accepted, parked byte after full, else hold
    always_ff @(posedge clock) begin
        if (reset)
            r_dout <= '0;
        else if (bus.lfd_state)
            r_dout <= r_hold_hdr;
        else if (bus.ld_state && !bus.fifo_full)
            r_dout <= bus.data_in;
        else if (bus.laf_state)
            r_dout <= r_full_byte;
    end

    // Capture header, the byte refused by a full FIFO, and the trailing parity byte
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hold_hdr   <= '0;
            r_full_byte  <= '0;
            r_pkt_parity <= '0;
        end else begin
            if (w_hdr_cap)
                r_hold_hdr <= bus.data_in;
            if (bus.ld_state && bus.fifo_full)
                r_full_byte <= bus.data_in;
            if (bus.ld_state && !bus.pkt_valid && !bus.fifo_full)
                r_pkt_parity <= bus.data_in;
        end
    end

    // End-of-packet flags; clears take priority over sets
    always_ff @(posedge clock) begin
        if (reset) begin
            r_parity_done   <= 1'b0;
            r_parity_done_d <= 1'b0;
            r_low_pkt_vld   <= 1'b0;
        end else begin
            r_parity_done_d <= r_parity_done;
            if (bus.detect_add)
                r_parity_done <= 1'b0;
            else if ((bus.ld_state && !bus.fifo_full && !bus.pkt_valid) ||
                     (bus.laf_state && r_low_pkt_vld && !r_parity_done))
                r_parity_done <= 1'b1;
            if (bus.rst_int_reg)
                r_low_pkt_vld <= 1'b0;
            else if (bus.ld_state && !bus.pkt_valid)
                r_low_pkt_vld <= 1'b1;
        end
    end

    // Parity and length verdicts, taken once as parity_done rises
    always_ff @(posedge clock) begin
        if (reset) begin
            r_err     <= 1'b0;
            r_len_err <= 1'b0;
        end else if (w_hdr_cap) begin
            r_err     <= 1'b0;
            r_len_err <= 1'b0;
        end else if (w_check) begin
            r_err     <= w_err_nxt;
            r_len_err <= w_len_err_nxt;
        end
    end

    // Saturating count of packets failing either check; only reset clears it
    always_ff @(posedge clock) begin
        if (reset)
            r_err_count <= '0;
        else if (w_check && (w_err_nxt || w_len_err_nxt) && (r_err_count != '1))
            r_err_count <= r_err_count + 1'b1;
    end

    assign bus.dout             = r_dout;
    assign bus.err              = r_err;
    assign bus.len_err          = r_len_err;
    assign bus.parity_done      = r_parity_done;
    assign bus.low_packet_valid = r_low_pkt_vld;
    assign bus.err_count        = r_err_count;

endmodule

// File: doc/router_reg_param.md
# router_reg_param

Parametrised next-generation packet register stage for the 1xN router, between the router FSM and the per-destination FIFOs.
- Latches the header, streams payload to the FIFOs, and holds the byte that arrives while the FIFO is full.
- Computes parity and checks it against the trailing parity byte.
- Adds what the fixed 8-bit stage lacks: configurable width and address field, selectable parity coverage, a header-length check, and a saturating error counter.

## Interface
- DATA_W, 8: data byte width (≥4).
- ADDR_W, 2: header address field width (header[ADDR_W-1:0]); length field LEN_W = DATA_W-ADDR_W is header[DATA_W-1:ADDR_W].
- PARITY_MODE, 0: 0 = parity covers header+payload; 1 = payload only.
- CNT_W, 4: error counter width.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- pkt_valid  in  1  packet body valid from source.
- fifo_full  in  1  selected destination FIFO full.
- detect_add  in  1  FSM: header byte present.
- lfd_state  in  1  FSM: load first data (header) to FIFO.
- ld_state  in  1  FSM: load payload/parity.
- laf_state  in  1  FSM: load after full.
- full_state  in  1  FSM: FIFO-full wait.
- rst_int_reg  in  1  FSM: clear low_packet_valid.
- data_in  in  DATA_W  input byte.
- dout  out  DATA_W  byte to FIFO.
- err  out  1  parity mismatch.
- len_err  out  1  payload count ≠ header length.
- parity_done  out  1  parity byte captured.
- low_packet_valid  out  1  pkt_valid fell during ld_state.
- err_count  out  CNT_W  saturating count of bad packets.

## Operation
- All outputs and internal registers reset to 0.
- Header capture: detect_add && pkt_valid -> hold_hdr <= data_in; int_parity, pay_cnt, err, len_err, parity_done cleared. detect_add's clear wins over any simultaneous set.
- dout priority, first match wins:
  - lfd_state -> hold_hdr.
  - ld_state && !fifo_full -> data_in.
  - laf_state -> full_byte.
  - otherwise hold.
- ld_state && fifo_full -> full_byte <= data_in.
- Parity accumulation:
  - lfd_state && PARITY_MODE==0 -> int_parity ^= hold_hdr.
  - ld_state && pkt_valid && !full_state -> int_parity ^= data_in; pay_cnt += 1, saturating at 2^LEN_W-1.
- Packet parity: ld_state && !pkt_valid && !fifo_full -> pkt_parity <= data_in.
- parity_done:
  - Set by ld_state && !fifo_full && !pkt_valid, or by laf_state && low_packet_valid && !parity_done.
  - Cleared by detect_add.
- low_packet_valid: set by ld_state && !pkt_valid; cleared by rst_int_reg (clear wins).
- Checks, in the cycle where parity_done==1 and the previous cycle's parity_done==0 (rising):
  - err <= (int_parity != pkt_parity).
  - len_err <= (pay_cnt != hold_hdr[DATA_W-1:ADDR_W]).
  - If either check fails, err_count += 1, saturating at 2^CNT_W-1. Counter cleared only by reset.
- Reset mid-packet: all state returns to 0 on the next edge; the partial packet is discarded.

## Timing
- Every output is registered; dout appears 1 cycle after the qualifying state input.
- err, len_err and err_count update 1 cycle after parity_done rises; they hold until the next detect_add (err, len_err) or reset.
- fifo_full during ld_state: the byte is held in full_byte and emitted 1 cycle after laf_state.
- Payload bytes arriving with full_state high are excluded from parity and count.

## Structure
- Shared package router_pkg:
  - DATA_W/ADDR_W defaults.
  - LEN_W derivation function.
  - PARITY_MODE encodings PAR_ALL=0, PAR_PAYLOAD=1.
- Sub-module router_parity_acc: int_parity XOR accumulator plus pay_cnt saturating counter, with clear/enable inputs. The top level holds the dout mux, full_byte, flags and err_count.

## Test plan
- Good packet, DATA_W=8, ADDR_W=2, header 8'h36 (len 13, addr 2), 13 random bytes, correct parity byte:
  - dout = 8'h36 one cycle after lfd_state.
  - parity_done=1, err=0, len_err=0, err_count=0.
- Same packet with the parity byte bit 0 flipped: err=1 one cycle after parity_done, err_count=1.
- 12 payload bytes with header length 13: len_err=1, err=0 (correct parity), err_count increments once.
- fifo_full asserted on payload bytes 11 and 12:
  - dout holds; byte 12 goes to full_byte.
  - After laf_state, dout = byte 12; parity still correct.
- PARITY_MODE=1: parity byte = XOR of payload only -> err=0; header-inclusive parity -> err=1.
- 16 bad packets with CNT_W=4: err_count saturates at 4'hF.
- Reset asserted mid-payload: all outputs 0 next cycle.
